// File: rtl/pkt_class_pkg.sv
// Shared types and constants for the serial packet classifier.
//   state_e        : classifier FSM state encoding
//   PORT_W / SID_W : widths of the header port field and session-ID field
//   DEF_PREAMBLE   : default preamble pattern, MSB received first
//   PORT_*         : well-known port numbers used for channel tables
package pkt_class_pkg;

    typedef enum logic [1:0] {
        ST_HUNT     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_CLASSIFY = 2'd2
    } state_e;

    localparam int PORT_W = 16;
    localparam int SID_W  = 8;

    localparam logic [31:0] DEF_PREAMBLE = 32'hA5A5A5A5;

    localparam logic [PORT_W-1:0] PORT_SKYPE    = 16'd23399;
    localparam logic [PORT_W-1:0] PORT_FTP_DATA = 16'd20;
    localparam logic [PORT_W-1:0] PORT_HTTPS    = 16'd443;
    localparam logic [PORT_W-1:0] PORT_TELNET   = 16'd23;
    localparam logic [PORT_W-1:0] PORT_SSH      = 16'd22;
    localparam logic [PORT_W-1:0] PORT_SMTP     = 16'd25;
    localparam logic [PORT_W-1:0] PORT_SNMP     = 16'd161;
    localparam logic [PORT_W-1:0] PORT_NNTPS    = 16'd563;

endpackage

// File: rtl/pkt_class_engine_pre.sv
// Preamble detector: shifts the serial stream while enabled and flags a match of the
// last 32 bits (including the bit currently on data_i) against PREAMBLE.
//   clk_i, rst_n_i : clock, async active-low reset
//   shift_i        : shift enable (hunting)
//   clear_i        : synchronous clear of the shift history
//   data_i         : serial bit
//   match_o        : combinational match, only while shift_i is high
module pkt_preamble_det
    import pkt_class_pkg::*;
#(
    parameter logic [31:0] PREAMBLE = DEF_PREAMBLE
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic shift_i,
    input  logic clear_i,
    input  logic data_i,
    output logic match_o
);

    // Only 31 history bits are stored; the 32nd is the live input bit.
    logic [30:0] pre_q;
    logic [31:0] pre_d;

    assign pre_d   = {pre_q, data_i};
    assign match_o = shift_i && (pre_d == PREAMBLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_q <= '0;
        end else if (clear_i) begin
            pre_q <= '0;
        end else if (shift_i) begin
            pre_q <= pre_d[30:0];
        end
    end

endmodule

// File: rtl/pkt_class_engine.sv
// Serial packet classifier top level: FSM, header field capture, channel match,
// saturating counters and per-channel session table.
//   clk_i, rst_n_i         : clock (one bit per cycle), async active-low reset
//   data_i                 : serial bit stream
//   clr_i                  : sync clear of counters and session state
//   cfg_port_i/en_i/sess_i : channel table (port, enable, session tracking)
//   pkt_cnt_o, sess_cnt_o  : per-channel packet / new-session counts
//   total_cnt_o            : completed packets; other_cnt_o: unmatched packets
//   pkt_valid_o/hit_o/ch_o : per-packet result pulse
//   busy_o                 : capturing or classifying
//
// state        | meaning
// ST_HUNT      | searching the stream for the preamble
// ST_CAPTURE   | receiving PKT_BITS packet bits, grabbing port and session fields
// ST_CLASSIFY  | one cycle: match port, counters update on the exit edge
module pkt_class_engine
    import pkt_class_pkg::*;
#(
    parameter logic [31:0] PREAMBLE = DEF_PREAMBLE,
    parameter int          PKT_BITS = 256,
    parameter int          PORT_OFS = 64,
    parameter int          SES_OFS  = 136,
    parameter int          NUM_CH   = 8,
    parameter int          CNT_W    = 8,
    parameter int          TOT_W    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      data_i,
    input  logic                      clr_i,
    input  logic [NUM_CH*PORT_W-1:0]  cfg_port_i,
    input  logic [NUM_CH-1:0]         cfg_en_i,
    input  logic [NUM_CH-1:0]         cfg_sess_i,
    output logic [NUM_CH*CNT_W-1:0]   pkt_cnt_o,
    output logic [NUM_CH*CNT_W-1:0]   sess_cnt_o,
    output logic [TOT_W-1:0]          total_cnt_o,
    output logic [TOT_W-1:0]          other_cnt_o,
    output logic                      pkt_valid_o,
    output logic                      pkt_hit_o,
    output logic [3:0]                pkt_ch_o,
    output logic                      busy_o
);

    localparam int CNT_BW = $clog2(PKT_BITS);
    // Bits-remaining counter values during which each field arrives.
    localparam logic [CNT_BW-1:0] BIT_LAST = CNT_BW'(PKT_BITS - 1);
    localparam logic [CNT_BW-1:0] PORT_HI  = CNT_BW'(PKT_BITS - 1 - PORT_OFS);
    localparam logic [CNT_BW-1:0] PORT_LO  = CNT_BW'(PKT_BITS - PORT_OFS - PORT_W);
    localparam logic [CNT_BW-1:0] SID_HI   = CNT_BW'(PKT_BITS - 1 - SES_OFS);
    localparam logic [CNT_BW-1:0] SID_LO   = CNT_BW'(PKT_BITS - SES_OFS - SID_W);

    state_e                          state_q, state_d;
    logic [CNT_BW-1:0]               bit_cnt_q, bit_cnt_d;
    logic [PORT_W-1:0]               port_q, port_d;
    logic [SID_W-1:0]                sid_q, sid_d;
    logic                            pre_match;

    logic [NUM_CH-1:0]               hit_oh;
    logic                            hit;
    logic [3:0]                      hit_ch;
    logic                            classify;

    logic [NUM_CH-1:0][CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]    sess_cnt_q, sess_cnt_d;
    logic [NUM_CH-1:0]               sess_vld_q, sess_vld_d;
    logic [NUM_CH-1:0][SID_W-1:0]    last_sid_q, last_sid_d;
    logic [TOT_W-1:0]                total_q, total_d;
    logic [TOT_W-1:0]                other_q, other_d;
    logic                            pkt_valid_q, pkt_hit_q;
    logic [3:0]                      pkt_ch_q;

    assign classify = (state_q == ST_CLASSIFY);

    // History is wiped on the way back to HUNT so the next preamble needs 32 fresh bits.
    pkt_preamble_det #(.PREAMBLE(PREAMBLE)) u_pre (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .shift_i (state_q == ST_HUNT),
        .clear_i (classify),
        .data_i  (data_i),
        .match_o (pre_match)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        port_d    = port_q;
        sid_d     = sid_q;
        case (state_q)
            ST_HUNT: begin
                if (pre_match) begin
                    state_d   = ST_CAPTURE;
                    bit_cnt_d = BIT_LAST;
                end
            end
            ST_CAPTURE: begin
                if (bit_cnt_q <= PORT_HI && bit_cnt_q >= PORT_LO)
                    port_d = {port_q[PORT_W-2:0], data_i};
                if (bit_cnt_q <= SID_HI && bit_cnt_q >= SID_LO)
                    sid_d = {sid_q[SID_W-2:0], data_i};
                if (bit_cnt_q == '0)
                    state_d = ST_CLASSIFY;
                else
                    bit_cnt_d = bit_cnt_q - CNT_BW'(1);
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // Descending scan so the lowest matching channel is the one left standing.
    always_comb begin
        hit_oh = '0;
        hit_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cfg_en_i[i] && (cfg_port_i[PORT_W*i +: PORT_W] == port_q)) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_ch    = 4'(i);
            end
        end
    end
    assign hit = |hit_oh;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        sess_cnt_d = sess_cnt_q;
        sess_vld_d = sess_vld_q;
        last_sid_d = last_sid_q;
        total_d    = total_q;
        other_d    = other_q;
        if (clr_i) begin
            pkt_cnt_d  = '0;
            sess_cnt_d = '0;
            sess_vld_d = '0;
            last_sid_d = '0;
            total_d    = '0;
            other_d    = '0;
        end else if (classify) begin
            if (total_q != '1)
                total_d = total_q + TOT_W'(1);
            if (!hit && other_q != '1)
                other_d = other_q + TOT_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit_oh[i]) begin
                    if (pkt_cnt_q[i] != '1)
                        pkt_cnt_d[i] = pkt_cnt_q[i] + CNT_W'(1);
                    // Only a strictly newer session ID counts; repeats and wraps are ignored.
                    if (cfg_sess_i[i] && (!sess_vld_q[i] || sid_q > last_sid_q[i])) begin
                        if (sess_cnt_q[i] != '1)
                            sess_cnt_d[i] = sess_cnt_q[i] + CNT_W'(1);
                        last_sid_d[i] = sid_q;
                        sess_vld_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_HUNT;
            bit_cnt_q   <= '0;
            port_q      <= '0;
            sid_q       <= '0;
            pkt_cnt_q   <= '0;
            sess_cnt_q  <= '0;
            sess_vld_q  <= '0;
            last_sid_q  <= '0;
            total_q     <= '0;
            other_q     <= '0;
            pkt_valid_q <= 1'b0;
            pkt_hit_q   <= 1'b0;
            pkt_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            port_q      <= port_d;
            sid_q       <= sid_d;
            pkt_cnt_q   <= pkt_cnt_d;
            sess_cnt_q  <= sess_cnt_d;
            sess_vld_q  <= sess_vld_d;
            last_sid_q  <= last_sid_d;
            total_q     <= total_d;
            other_q     <= other_d;
            pkt_valid_q <= classify;
            pkt_hit_q   <= classify && hit;
            pkt_ch_q    <= classify ? hit_ch : 4'd0;
        end
    end

    assign pkt_cnt_o   = pkt_cnt_q;
    assign sess_cnt_o  = sess_cnt_q;
    assign total_cnt_o = total_q;
    assign other_cnt_o = other_q;
    assign pkt_valid_o = pkt_valid_q;
    assign pkt_hit_o   = pkt_hit_q;
    assign pkt_ch_o    = pkt_ch_q;
    assign busy_o      = (state_q != ST_HUNT);

endmodule

// File: tb/tb_pkt_class_engine.sv
// Bench for pkt_class_engine: directed packets built from field values, a transaction
// level model of the counters/session table, a per-cycle compare process, and literal
// end-of-test expectations. A 160-bit packet length keeps the 300-packet saturation run
// short while leaving the port and session fields at their usual offsets.
module tb_pkt_class_engine;
    import pkt_class_pkg::*;

    localparam int NUM_CH   = 8;
    localparam int CNT_W    = 8;
    localparam int TOT_W    = 32;
    localparam int PKT_BITS = 160;
    localparam int PORT_OFS = 64;
    localparam int SES_OFS  = 136;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     data = 1'b0;
    logic                     clr = 1'b0;
    logic [NUM_CH*16-1:0]     cfg_port;
    logic [NUM_CH-1:0]        cfg_en = '1;
    logic [NUM_CH-1:0]        cfg_sess = 8'h01;
    logic [NUM_CH*CNT_W-1:0]  pkt_cnt, sess_cnt;
    logic [TOT_W-1:0]         total_cnt, other_cnt;
    logic                     pkt_valid, pkt_hit, busy;
    logic [3:0]               pkt_ch;

    int tb_port [NUM_CH];

    always #5 clk = ~clk;

    always_comb begin
        cfg_port = '0;
        for (int i = 0; i < NUM_CH; i++) cfg_port[16*i +: 16] = tb_port[i][15:0];
    end

    pkt_class_engine #(
        .PKT_BITS(PKT_BITS), .PORT_OFS(PORT_OFS), .SES_OFS(SES_OFS),
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TOT_W(TOT_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .clr_i(clr),
        .cfg_port_i(cfg_port), .cfg_en_i(cfg_en), .cfg_sess_i(cfg_sess),
        .pkt_cnt_o(pkt_cnt), .sess_cnt_o(sess_cnt),
        .total_cnt_o(total_cnt), .other_cnt_o(other_cnt),
        .pkt_valid_o(pkt_valid), .pkt_hit_o(pkt_hit), .pkt_ch_o(pkt_ch), .busy_o(busy)
    );

    typedef struct { int due; bit hit; int ch; bit sess_en; int sid; } ev_t;

    ev_t     evq [$];
    ev_t     ev_cur;
    int      m_pkt [NUM_CH];
    int      m_sess [NUM_CH];
    int      m_last [NUM_CH];
    bit      m_vld [NUM_CH];
    longint  m_tot, m_oth;
    bit      exp_busy, exp_valid, exp_hit;
    int      exp_ch;
    int      cyc = 0, checks = 0, errors = 0, n_pulse = 0, last_ch_seen = 0;
    bit      last_hit_seen = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d", name, idx, cyc, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_pkt[i] = 0; m_sess[i] = 0; m_last[i] = 0; m_vld[i] = 0;
        end
        m_tot = 0; m_oth = 0;
    endfunction

    function automatic void model_apply(input ev_t e);
        if (m_tot < 64'hFFFF_FFFF) m_tot++;
        if (!e.hit) begin
            if (m_oth < 64'hFFFF_FFFF) m_oth++;
        end else begin
            if (m_pkt[e.ch] < CNT_MAX) m_pkt[e.ch]++;
            if (e.sess_en && (!m_vld[e.ch] || e.sid > m_last[e.ch])) begin
                if (m_sess[e.ch] < CNT_MAX) m_sess[e.ch]++;
                m_last[e.ch] = e.sid;
                m_vld[e.ch]  = 1;
            end
        end
    endfunction

    // First enabled channel (lowest index) whose port equals the packet port.
    function automatic ev_t classify(input int port, input int sid);
        ev_t e;
        e.due = 0; e.hit = 0; e.ch = 0; e.sess_en = 0; e.sid = sid;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!e.hit && cfg_en[i] && tb_port[i] == port) begin
                e.hit = 1; e.ch = i;
            end
        end
        if (e.hit) e.sess_en = cfg_sess[e.ch];
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        exp_valid = 0; exp_hit = 0; exp_ch = 0;
        if (!rst_n) begin
            model_clear();
            evq.delete();
            exp_busy = 0;
        end else begin
            if (evq.size() > 0 && evq[0].due == cyc) begin
                ev_cur    = evq.pop_front();
                exp_valid = 1;
                exp_hit   = ev_cur.hit;
                exp_ch    = ev_cur.hit ? ev_cur.ch : 0;
                exp_busy  = 0;
                if (!clr) model_apply(ev_cur);
            end
            if (clr) model_clear();
        end
        chk("pkt_valid", 0, pkt_valid, exp_valid);
        chk("pkt_hit", 0, pkt_hit, exp_hit);
        chk("pkt_ch", 0, pkt_ch, exp_ch);
        chk("busy", 0, busy, exp_busy);
        chk("total_cnt", 0, total_cnt, m_tot);
        chk("other_cnt", 0, other_cnt, m_oth);
        for (int i = 0; i < NUM_CH; i++) begin
            chk("pkt_cnt", i, pkt_cnt[CNT_W*i +: CNT_W], m_pkt[i]);
            chk("sess_cnt", i, sess_cnt[CNT_W*i +: CNT_W], m_sess[i]);
        end
        if (pkt_valid === 1'b1) begin
            n_pulse++;
            last_hit_seen = pkt_hit;
            last_ch_seen  = pkt_ch;
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        data = b;
    endtask

    task automatic do_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // abort_at >= 0 pulls reset instead of sending that packet bit.
    task automatic send_packet(input int port, input int sid, input logic [31:0] fill,
                               input int abort_at, input bit clr_upd);
        bit          pk [PKT_BITS];
        logic [31:0] pre;
        ev_t         e;
        pre = DEF_PREAMBLE;
        for (int k = 0; k < PKT_BITS; k++) pk[k] = fill[31 - (k % 32)];
        for (int j = 0; j < 16; j++) pk[PORT_OFS + j] = port[15 - j];
        for (int j = 0; j < 8; j++)  pk[SES_OFS + j]  = sid[7 - j];
        for (int k = 0; k < 32; k++) send_bit(pre[31 - k]);
        @(posedge clk);
        exp_busy = 1;
        for (int k = 0; k < PKT_BITS; k++) begin
            if (k == abort_at) begin
                @(negedge clk); rst_n = 1'b0; data = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            send_bit(pk[k]);
        end
        @(posedge clk);
        e = classify(port, sid);
        e.due = cyc + 2;
        evq.push_back(e);
        @(negedge clk); data = 1'b0; clr = clr_upd;
        @(negedge clk); clr = 1'b0;
    endtask

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        tb_port[0] = 23399; tb_port[1] = 20;  tb_port[2] = 443; tb_port[3] = 23;
        tb_port[4] = 22;    tb_port[5] = 25;  tb_port[6] = 161; tb_port[7] = 563;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_total", 0, total_cnt, 0);
        chk("reset_busy", 0, busy, 0);
        chk("reset_pkt_cnt", 0, pkt_cnt, 0);
        repeat (4) send_bit(1'b0);

        // 1: port 443 -> channel 2
        p0 = n_pulse;
        send_packet(443, 0, 32'h0, -1, 0);
        chk("t1_pulses", 0, n_pulse - p0, 1);
        chk("t1_hit", 0, last_hit_seen, 1);
        chk("t1_ch", 0, last_ch_seen, 2);
        chk("t1_pkt_cnt", 2, pkt_cnt[2*CNT_W +: CNT_W], 1);
        chk("t1_total", 0, total_cnt, 1);

        // 2: sessions 5,5,7 then wrapped 3 on channel 0
        do_clr();
        send_packet(23399, 5, 32'h0, -1, 0);
        send_packet(23399, 5, 32'h0, -1, 0);
        send_packet(23399, 7, 32'h0, -1, 0);
        chk("t2_sess", 0, sess_cnt[0 +: CNT_W], 2);
        chk("t2_pkt", 0, pkt_cnt[0 +: CNT_W], 3);
        send_packet(23399, 3, 32'h0, -1, 0);
        chk("t2_sess_wrap", 0, sess_cnt[0 +: CNT_W], 2);
        chk("t2_pkt_wrap", 0, pkt_cnt[0 +: CNT_W], 4);

        // 3: miss, duplicate priority, disabled channel
        do_clr();
        send_packet(9999, 1, 32'h0, -1, 0);
        chk("t3_hit", 0, last_hit_seen, 0);
        chk("t3_ch", 0, last_ch_seen, 0);
        chk("t3_other", 0, other_cnt, 1);
        chk("t3_pkt_all", 0, pkt_cnt, 0);
        @(negedge clk); tb_port[4] = 8080; tb_port[6] = 8080;
        send_packet(8080, 1, 32'h0, -1, 0);
        chk("t3_dup_ch", 0, last_ch_seen, 4);
        chk("t3_dup_pkt", 4, pkt_cnt[4*CNT_W +: CNT_W], 1);
        chk("t3_dup_pkt", 6, pkt_cnt[6*CNT_W +: CNT_W], 0);
        @(negedge clk); cfg_en[2] = 1'b0;
        send_packet(443, 1, 32'h0, -1, 0);
        chk("t3_dis_other", 0, other_cnt, 2);
        chk("t3_dis_pkt", 2, pkt_cnt[2*CNT_W +: CNT_W], 0);
        @(negedge clk); cfg_en[2] = 1'b1; tb_port[4] = 22; tb_port[6] = 161;

        // 4: saturation
        do_clr();
        repeat (300) send_packet(20, 0, 32'h0, -1, 0);
        chk("t4_pkt_sat", 1, pkt_cnt[1*CNT_W +: CNT_W], 255);
        chk("t4_total", 0, total_cnt, 300);

        // 5: reset mid-packet, then a packet whose payload is full of preambles
        do_clr();
        send_packet(443, 0, 32'h0, -1, 0);
        send_packet(443, 0, 32'h0, 100, 0);
        chk("t5_total_rst", 0, total_cnt, 0);
        chk("t5_busy_rst", 0, busy, 0);
        p0 = n_pulse;
        send_packet(443, 9, 32'hA5A5A5A5, -1, 0);
        repeat (40) send_bit(1'b0);
        chk("t5_pulses", 0, n_pulse - p0, 1);
        chk("t5_total", 0, total_cnt, 1);
        chk("t5_pkt", 2, pkt_cnt[2*CNT_W +: CNT_W], 1);

        // 6: clr on the update edge
        do_clr();
        p0 = n_pulse;
        send_packet(443, 0, 32'h0, -1, 1);
        chk("t6_pulses", 0, n_pulse - p0, 1);
        chk("t6_total", 0, total_cnt, 0);
        chk("t6_pkt", 2, pkt_cnt[2*CNT_W +: CNT_W], 0);
        send_packet(443, 0, 32'h0, -1, 0);
        chk("t6_total_next", 0, total_cnt, 1);
        chk("t6_pkt_next", 2, pkt_cnt[2*CNT_W +: CNT_W], 1);

        repeat (4) send_bit(1'b0);
        chk("pending_events", 0, evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
